payment_controller: RTL and testbench
=====================================

# payment_controller

Sequencing controller for the payment datapath of the checkout: it latches the price of a scanned item, accumulates inserted coins, decides when payment is complete or cancelled, and computes the change as money inserted minus value to pay. It then dispenses that change one coin at a time over a ready/valid handshake. It sits between the barcode/price lookup logic, the coin acceptor and the change dispenser. All money quantities are 5-bit unsigned units (0..31).

## Interface
Parameters: none; widths fixed at 5 bits, denominations fixed at 10, 5, 2, 1.
- clk  in  1  system clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin a transaction with `price`
- price  in  5  value to pay, sampled when `start` is accepted
- coinValid  in  1  one coin presented this cycle
- coinValue  in  5  value of the presented coin
- cancel  in  1  customer abort
- changeReady  in  1  dispenser accepts `changeCoin` this cycle
- busy  out  1  high in every state except IDLE
- inserted  out  5  money accumulated in the current transaction
- remaining  out  5  price − inserted in COLLECT, 0 otherwise
- coinReject  out  1  one-cycle pulse: previous coin not accepted, return it
- changeValid  out  1  `changeCoin` is valid
- changeCoin  out  5  denomination to dispense (10/5/2/1), 0 when not valid
- paidPulse  out  1  one-cycle pulse: transaction completed with payment
- cancelPulse  out  1  one-cycle pulse: transaction cancelled, money refunded

## Operation
- States: IDLE, COLLECT, CHANGE, DONE. Internal registers: priceReg, inserted, changeAmt (all 5 bits), and a success flag.
- IDLE
  - `start` with price≠0: priceReg←price, inserted←0, go to COLLECT.
  - `start` with price=0 is ignored.
  - `coinValid` in IDLE: coinReject.
- COLLECT
  - Evaluated in priority order:
    1. `cancel`: changeAmt←inserted, success←0, go to CHANGE. A simultaneous coin is rejected.
    2. `coinValid` with coinValue=0: ignored.
    3. `coinValid` where the 6-bit sum inserted+coinValue > 31: coinReject, inserted unchanged.
    4. Otherwise inserted←inserted+coinValue. If the new inserted ≥ priceReg: changeAmt←new inserted − priceReg, success←1, go to CHANGE.
  - `start` in COLLECT is ignored.
- CHANGE
  - If changeAmt=0: go to DONE; changeValid is never raised.
  - Else changeValid=1 and changeCoin = largest of {10,5,2,1} that is ≤ changeAmt.
  - On changeValid∧changeReady: changeAmt←changeAmt−changeCoin. When the result is 0, go to DONE.
  - `cancel`, `start` and coins are ignored; any coin gets coinReject.
- DONE: one cycle. paidPulse=success, cancelPulse=¬success. Then go to IDLE, where inserted←0.
- Reset (asynchronous, any state): state←IDLE, and every register and output←0.

## Timing
- All outputs are registered and change only on the rising edge of clk, except during asynchronous reset.
- Reset value of every output is 0.
- coinReject is high for exactly the cycle after the offending coinValid sample.
- inserted updates the cycle after the coin is sampled.
- Transition COLLECT→CHANGE happens on the same edge that accepts the completing coin or samples cancel.
- changeValid rises on the first CHANGE cycle, one cycle after the completing coin or cancel edge.
- changeCoin is held stable while changeValid∧¬changeReady.
- With changeReady held high, one coin is dispensed per cycle and a new denomination appears on the next cycle.
- DONE follows the edge that dispenses the last coin, or follows the first CHANGE cycle when changeAmt=0.
- paidPulse/cancelPulse are high only in DONE. busy falls on the DONE→IDLE edge.
- A new `start` is accepted in the first IDLE cycle.

## Test plan
- start price=12; coins 5,5,5 with changeReady=1 → inserted 5,10,15; changeCoin 2 then 1; paidPulse once; busy low afterwards.
- start price=10; coin 10 → no changeValid; DONE one cycle later with paidPulse; inserted=10 in DONE, 0 in IDLE.
- start price=20; coins 5,2; cancel → change 5 then 2; cancelPulse=1, paidPulse=0.
- start price=31; coins 20,20 → second coin gives coinReject with inserted=20; coin 11 → paidPulse, no change. Cancel and a coin in the same cycle → coinReject, refund of the prior amount.
- price=9, coin 31 → change 22 dispensed as 10,10,2. Hold changeReady low 4 cycles on the first coin → changeCoin held at 10 with changeValid high throughout.
- Assert resetN low in mid-CHANGE, asynchronously → all outputs 0 immediately, state IDLE. After release, start price=3 with coin 3 → normal paidPulse.

Source files
------------

// File: rtl/payment_controller_if.sv
// Checkout payment bus: price/coin inputs, change dispenser
// handshake and transaction status back to the checkout logic.
interface payment_controller_if;
  logic       start;
  logic [4:0] price;
  logic       coinValid;
  logic [4:0] coinValue;
  logic       cancel;
  logic       changeReady;
  logic       busy;
  logic [4:0] inserted;
  logic [4:0] remaining;
  logic       coinReject;
  logic       changeValid;
  logic [4:0] changeCoin;
  logic       paidPulse;
  logic       cancelPulse;

  modport master (
    output start, price, coinValid, coinValue,
    output cancel, changeReady,
    input  busy, inserted, remaining, coinReject,
    input  changeValid, changeCoin, paidPulse, cancelPulse
  );

  modport slave (
    input  start, price, coinValid, coinValue,
    input  cancel, changeReady,
    output busy, inserted, remaining, coinReject,
    output changeValid, changeCoin, paidPulse, cancelPulse
  );
endinterface

// File: rtl/payment_controller.sv
// Payment sequencer: latch price, collect coins, then pay out
// change one denomination at a time over ready/valid.
module payment_controller (
  input logic clk,
  input logic resetN,
  payment_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHANGE,
    DONE
  } state_t;

  state_t     state, state_n;
  logic [4:0] price_q, price_n;
  logic [4:0] ins_q, ins_n;
  logic [4:0] amt_q, amt_n;
  logic       succ_q, succ_n;
  logic       rej_n;
  logic [5:0] sum;
  logic [4:0] coin_c;

  function automatic logic [4:0] denom(input logic [4:0] a);
    logic [4:0] d;
    d = 5'd0;
    unique case (1'b1)
      (a >= 5'd10):                d = 5'd10;
      (a >= 5'd5  && a < 5'd10):   d = 5'd5;
      (a >= 5'd2  && a < 5'd5):    d = 5'd2;
      (a == 5'd1):                 d = 5'd1;
      default:                     d = 5'd0;
    endcase
    return d;
  endfunction

  assign sum    = {1'b0, ins_q} + {1'b0, bus.coinValue};
  assign coin_c = denom(amt_q);

  always_comb begin
    state_n = state;
    price_n = price_q;
    ins_n   = ins_q;
    amt_n   = amt_q;
    succ_n  = succ_q;
    rej_n   = 1'b0;
    case (state)
      IDLE: begin
        rej_n = bus.coinValid;
        if (bus.start && bus.price != 5'd0) begin
          price_n = bus.price;
          ins_n   = 5'd0;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          amt_n   = ins_q;
          succ_n  = 1'b0;
          rej_n   = bus.coinValid;
          state_n = CHANGE;
        end else if (bus.coinValid && bus.coinValue != 5'd0) begin
          if (sum[5]) begin
            rej_n = 1'b1;
          end else begin
            ins_n = sum[4:0];
            if (sum[4:0] >= price_q) begin
              amt_n   = sum[4:0] - price_q;
              succ_n  = 1'b1;
              state_n = CHANGE;
            end
          end
        end
      end
      CHANGE: begin
        rej_n = bus.coinValid;
        if (amt_q == 5'd0) begin
          state_n = DONE;
        end else if (bus.changeValid && bus.changeReady) begin
          amt_n = amt_q - coin_c;
          if (amt_n == 5'd0)
            state_n = DONE;
        end
      end
      DONE: begin
        rej_n   = bus.coinValid;
        ins_n   = 5'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line
  // up with the state they describe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      price_q         <= 5'd0;
      ins_q           <= 5'd0;
      amt_q           <= 5'd0;
      succ_q          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.inserted    <= 5'd0;
      bus.remaining   <= 5'd0;
      bus.coinReject  <= 1'b0;
      bus.changeValid <= 1'b0;
      bus.changeCoin  <= 5'd0;
      bus.paidPulse   <= 1'b0;
      bus.cancelPulse <= 1'b0;
    end else begin
      state           <= state_n;
      price_q         <= price_n;
      ins_q           <= ins_n;
      amt_q           <= amt_n;
      succ_q          <= succ_n;
      bus.busy        <= (state_n != IDLE);
      bus.inserted    <= ins_n;
      bus.remaining   <= (state_n == COLLECT) ?
                         (price_n - ins_n) : 5'd0;
      bus.coinReject  <= rej_n;
      bus.changeValid <= (state_n == CHANGE) &&
                         (amt_n != 5'd0);
      bus.changeCoin  <= (state_n == CHANGE) ?
                         denom(amt_n) : 5'd0;
      bus.paidPulse   <= (state_n == DONE) && succ_n;
      bus.cancelPulse <= (state_n == DONE) && !succ_n;
    end
  end

endmodule

// File: tb/tb_payment_controller.sv
// Scoreboard bench for payment_controller: expected events are
// queued by stimulus and consumed by a negedge monitor.
module tb_payment_controller;

  localparam logic [1:0] K_COIN = 2'd0;
  localparam logic [1:0] K_REJ  = 2'd1;
  localparam logic [1:0] K_PAID = 2'd2;
  localparam logic [1:0] K_CANC = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [4:0] val;
  } evt_t;

  logic clk;
  logic resetN;
  int   checks;
  int   errors;
  evt_t exp_q[$];

  payment_controller_if bus ();

  payment_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic expect_evt(input logic [1:0] k,
                            input logic [4:0] v);
    evt_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [1:0] k, input logic [4:0] v);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL evt: got kind %0d val %0d required none",
               k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL evt: got kind %0d val %0d required kind %0d val %0d",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetN) begin
      if (bus.coinReject) got(K_REJ, 5'd0);
      if (bus.changeValid && bus.changeReady)
        got(K_COIN, bus.changeCoin);
      if (bus.paidPulse)   got(K_PAID, 5'd0);
      if (bus.cancelPulse) got(K_CANC, 5'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] p);
    bus.start = 1'b1;
    bus.price = p;
    cyc();
    bus.start = 1'b0;
    bus.price = 5'd0;
  endtask

  task automatic coin(input logic [4:0] v);
    bus.coinValid = 1'b1;
    bus.coinValue = v;
    cyc();
    bus.coinValid = 1'b0;
    bus.coinValue = 5'd0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1;
    cyc();
    bus.cancel = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy) break;
      cyc();
    end
    chk("idle_timeout_busy", int'(bus.busy), 0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    resetN          = 1'b0;
    bus.start       = 1'b0;
    bus.price       = 5'd0;
    bus.coinValid   = 1'b0;
    bus.coinValue   = 5'd0;
    bus.cancel      = 1'b0;
    bus.changeReady = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_inserted", int'(bus.inserted), 0);
    chk("rst_change_valid", int'(bus.changeValid), 0);
    chk("rst_change_coin", int'(bus.changeCoin), 0);
    resetN = 1'b1;
    cyc();

    // price 12, coins 5,5,5 -> change 3 as 2,1
    bus.changeReady = 1'b1;
    expect_evt(K_COIN, 5'd2);
    expect_evt(K_COIN, 5'd1);
    expect_evt(K_PAID, 5'd0);
    do_start(5'd12);
    chk("t1_busy", int'(bus.busy), 1);
    chk("t1_remaining", int'(bus.remaining), 12);
    coin(5'd5);
    chk("t1_ins5", int'(bus.inserted), 5);
    chk("t1_rem7", int'(bus.remaining), 7);
    coin(5'd5);
    chk("t1_ins10", int'(bus.inserted), 10);
    coin(5'd5);
    chk("t1_ins15", int'(bus.inserted), 15);
    chk("t1_valid", int'(bus.changeValid), 1);
    chk("t1_coin2", int'(bus.changeCoin), 2);
    chk("t1_rem0", int'(bus.remaining), 0);
    wait_idle();
    chk("t1_ins_idle", int'(bus.inserted), 0);

    // price 10, exact coin -> no change
    expect_evt(K_PAID, 5'd0);
    do_start(5'd10);
    coin(5'd10);
    chk("t2_no_valid", int'(bus.changeValid), 0);
    chk("t2_coin0", int'(bus.changeCoin), 0);
    cyc();
    chk("t2_paid", int'(bus.paidPulse), 1);
    chk("t2_ins_done", int'(bus.inserted), 10);
    cyc();
    chk("t2_busy_low", int'(bus.busy), 0);
    chk("t2_ins_idle", int'(bus.inserted), 0);
    chk("t2_paid_low", int'(bus.paidPulse), 0);

    // price 20, coins 5,2, cancel -> refund 5,2
    expect_evt(K_COIN, 5'd5);
    expect_evt(K_COIN, 5'd2);
    expect_evt(K_CANC, 5'd0);
    do_start(5'd20);
    coin(5'd5);
    coin(5'd2);
    do_cancel();
    chk("t3_valid", int'(bus.changeValid), 1);
    chk("t3_coin5", int'(bus.changeCoin), 5);
    wait_idle();

    // price 31: overflow reject, then exact completion
    do_start(5'd31);
    coin(5'd20);
    expect_evt(K_REJ, 5'd0);
    coin(5'd20);
    chk("t4_reject", int'(bus.coinReject), 1);
    chk("t4_ins20", int'(bus.inserted), 20);
    expect_evt(K_PAID, 5'd0);
    coin(5'd11);
    chk("t4_ins31", int'(bus.inserted), 31);
    chk("t4_rej_low", int'(bus.coinReject), 0);
    wait_idle();

    // cancel with simultaneous coin -> reject, refund 7
    expect_evt(K_REJ, 5'd0);
    expect_evt(K_COIN, 5'd5);
    expect_evt(K_COIN, 5'd2);
    expect_evt(K_CANC, 5'd0);
    do_start(5'd31);
    coin(5'd7);
    bus.cancel    = 1'b1;
    bus.coinValid = 1'b1;
    bus.coinValue = 5'd3;
    cyc();
    bus.cancel    = 1'b0;
    bus.coinValid = 1'b0;
    bus.coinValue = 5'd0;
    chk("t4c_reject", int'(bus.coinReject), 1);
    chk("t4c_ins7", int'(bus.inserted), 7);
    wait_idle();

    // price 9, coin 31 -> change 22 with backpressure
    bus.changeReady = 1'b0;
    expect_evt(K_COIN, 5'd10);
    expect_evt(K_COIN, 5'd10);
    expect_evt(K_COIN, 5'd2);
    expect_evt(K_PAID, 5'd0);
    do_start(5'd9);
    coin(5'd31);
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_valid", int'(bus.changeValid), 1);
      chk("t5_hold_coin", int'(bus.changeCoin), 10);
      cyc();
    end
    bus.changeReady = 1'b1;
    wait_idle();

    // async reset in mid-CHANGE
    bus.changeReady = 1'b0;
    do_start(5'd20);
    coin(5'd15);
    do_cancel();
    expect_evt(K_COIN, 5'd10);
    bus.changeReady = 1'b1;
    cyc();
    bus.changeReady = 1'b0;
    chk("t6_pre_coin5", int'(bus.changeCoin), 5);
    #2;
    resetN = 1'b0;
    #1;
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_valid", int'(bus.changeValid), 0);
    chk("t6_rst_coin", int'(bus.changeCoin), 0);
    chk("t6_rst_ins", int'(bus.inserted), 0);
    cyc();
    resetN = 1'b1;
    cyc();
    chk("t6_idle_busy", int'(bus.busy), 0);
    bus.changeReady = 1'b1;
    expect_evt(K_PAID, 5'd0);
    do_start(5'd3);
    coin(5'd3);
    wait_idle();

    cyc();
    cyc();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
